// File: rtl/vc_table_pkg.sv
// Shared types and helpers for the runtime-programmable VC lookup shim.
// The entry struct uses the bundle's router/VC address widths.
package vc_table_pkg;

  localparam int ENTRY_DEST_W = 4;
  localparam int ENTRY_VC_W   = 2;

  typedef struct packed {
    logic [ENTRY_DEST_W-1:0] dest;
    logic [ENTRY_VC_W-1:0]   vc;
  } vc_entry_t;

  function automatic int clog2_min1(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/vc_table_cam.sv
// Combinational destination match over the VC table.
// The highest-index matching entry wins; no match falls back to entry 0.
module vc_table_cam
  import vc_table_pkg::*;
#(
  parameter int NUM_ENTRIES = 4
) (
  input  vc_entry_t [NUM_ENTRIES-1:0] entries,
  input  logic [ENTRY_DEST_W-1:0]     dest,
  output logic [ENTRY_VC_W-1:0]       vc,
  output logic                        miss
);

  always_comb begin
    vc   = entries[0].vc;
    miss = 1'b1;
    // Ascending scan: later matches overwrite earlier ones.
    for (int k = 0; k < NUM_ENTRIES; k++) begin
      if (entries[k].dest == dest) begin
        vc   = entries[k].vc;
        miss = 1'b0;
      end
    end
  end

endmodule

// File: rtl/vc_table_dyn.sv
// VC tagging shim: looks up the destination VC per flit (or per packet when
// locked), with a one-entry registered output stage and a writable table.
module vc_table_dyn
  import vc_table_pkg::*;
#(
  parameter int N_ADDR_WIDTH  = ENTRY_DEST_W,
  parameter int VC_ADDR_WIDTH = ENTRY_VC_W,
  parameter int DATA_WIDTH    = 128,
  parameter int NUM_ENTRIES   = 4,
  parameter int IDX_WIDTH     = clog2_min1(NUM_ENTRIES),
  parameter logic [N_ADDR_WIDTH-1:0]  DEST [0:NUM_ENTRIES-1] = '{default: 1},
  parameter logic [VC_ADDR_WIDTH-1:0] VC   [0:NUM_ENTRIES-1] = '{default: 1},
  parameter bit PACKET_LOCK = 1'b1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [DATA_WIDTH-1:0]    i_data,
  input  logic [N_ADDR_WIDTH-1:0]  i_dest,
  input  logic                     i_sop,
  input  logic                     i_eop,
  input  logic                     i_valid,
  output logic                     o_ready,
  output logic [DATA_WIDTH-1:0]    o_data,
  output logic [N_ADDR_WIDTH-1:0]  o_dest,
  output logic                     o_sop,
  output logic                     o_eop,
  output logic [VC_ADDR_WIDTH-1:0] o_vc,
  output logic                     o_miss,
  output logic                     o_valid,
  input  logic                     i_ready,
  input  logic                     cfg_wr,
  input  logic [IDX_WIDTH-1:0]     cfg_idx,
  input  logic [N_ADDR_WIDTH-1:0]  cfg_dest,
  input  logic [VC_ADDR_WIDTH-1:0] cfg_vc,
  output logic [15:0]              miss_count
);

  vc_entry_t [NUM_ENTRIES-1:0] tbl;
  vc_entry_t [NUM_ENTRIES-1:0] tbl_rst;

  logic                     accept;
  logic                     idx_ok;
  logic [VC_ADDR_WIDTH-1:0] look_vc;
  logic                     look_miss;
  logic                     use_lock;
  logic [VC_ADDR_WIDTH-1:0] sel_vc;
  logic                     sel_miss;
  logic                     lock_valid;
  logic [VC_ADDR_WIDTH-1:0] lock_vc;

  always_comb begin
    tbl_rst = '0;
    for (int k = 0; k < NUM_ENTRIES; k++) begin
      tbl_rst[k].dest = DEST[k];
      tbl_rst[k].vc   = VC[k];
    end
  end

  assign o_ready = !o_valid || i_ready;
  assign accept  = i_valid && o_ready;
  assign idx_ok  = int'(cfg_idx) < NUM_ENTRIES;

  vc_table_cam #(
    .NUM_ENTRIES(NUM_ENTRIES)
  ) u_cam (
    .entries(tbl),
    .dest   (i_dest),
    .vc     (look_vc),
    .miss   (look_miss)
  );

  // Body flits of a locked packet reuse the head's VC and never count as misses.
  assign use_lock = PACKET_LOCK && lock_valid && !i_sop;
  assign sel_vc   = use_lock ? lock_vc : look_vc;
  assign sel_miss = use_lock ? 1'b0 : look_miss;

  // Writes land at the edge, so a same-cycle lookup sees the old table.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tbl <= tbl_rst;
    end else if (cfg_wr && idx_ok) begin
      tbl[cfg_idx].dest <= cfg_dest;
      tbl[cfg_idx].vc   <= cfg_vc;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lock_valid <= 1'b0;
      lock_vc    <= '0;
    end else if (PACKET_LOCK && accept) begin
      if (i_sop) begin
        lock_vc    <= look_vc;
        lock_valid <= !i_eop;
      end else if (i_eop) begin
        lock_valid <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_valid <= 1'b0;
      o_data  <= '0;
      o_dest  <= '0;
      o_sop   <= 1'b0;
      o_eop   <= 1'b0;
      o_vc    <= '0;
      o_miss  <= 1'b0;
    end else if (accept) begin
      o_valid <= 1'b1;
      o_data  <= i_data;
      o_dest  <= i_dest;
      o_sop   <= i_sop;
      o_eop   <= i_eop;
      o_vc    <= sel_vc;
      o_miss  <= sel_miss;
    end else if (i_ready) begin
      o_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      miss_count <= '0;
    end else if (accept && sel_miss && (miss_count != 16'hFFFF)) begin
      miss_count <= miss_count + 16'd1;
    end
  end

endmodule
